// File: rtl/data_memory_pkg.sv
// ----------------------------------------------------------------------------
// data_memory_pkg
// Shared definitions for the data memory access controller.
//   - ADDR_W_DEF / DATA_W_DEF : default address and data widths
//   - state_t                 : controller states (ST_IDLE, ST_ACCESS)
//   - req_id_t                : requester identity (REQ_A = 0, REQ_B = 1)
// ----------------------------------------------------------------------------
package data_memory_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// ----------------------------------------------------------------------------
// rr_arbiter_2
// Two-way combinational pick. A lone request always wins. On a tie the
// requester that did not win last time is chosen (round-robin).
// Build option: define ARB_FIXED_PRIORITY_EN to make requester 0 win every
// tie; `last` is then ignored and requester 1 can starve.
// Ports:
//   req  [1:0] in   request vector, bit 0 = port A, bit 1 = port B
//   last       in   requester granted most recently
//   win  [1:0] out  one-hot winner, 2'b00 when no request
// ----------------------------------------------------------------------------
module rr_arbiter_2
    import data_memory_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_t    last,
    output logic [1:0] win
);

    always_comb begin
        win = 2'b00;
        case (req)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
`ifdef ARB_FIXED_PRIORITY_EN
            2'b11:   win = 2'b01;
`else
            2'b11:   win = (last == REQ_A) ? 2'b10 : 2'b01;
`endif
            default: win = 2'b00;
        endcase
    end

endmodule

// File: rtl/data_memory_arbiter.sv
// ----------------------------------------------------------------------------
// data_memory_arbiter
// Serialises read/write accesses from two requesters (A: CPU datapath,
// B: loader/debug) onto the single port of the 32 x 8-bit data memory.
// One access takes two cycles: IDLE (arbitrate, latch the winner's fields)
// then ACCESS (strobe the memory, capture read data). All outputs are
// registered.
// Build option: ARB_FIXED_PRIORITY_EN (see rr_arbiter_2) selects fixed
// priority for port A instead of round-robin.
// Ports:
//   clock              in   system clock, rising edge
//   clear_n            in   asynchronous active-low reset
//   req_a / req_b      in   access request, held stable until gnt
//   we_a / we_b        in   1 = write, 0 = read
//   addr_a / addr_b    in   access address (ADDR_W)
//   wdata_a / wdata_b  in   write data (DATA_W)
//   gnt_a / gnt_b      out  one-cycle pulse, request accepted
//   rvalid_a/rvalid_b  out  one-cycle pulse, rdata_x holds the read result
//   rdata_a / rdata_b  out  read data, held until that port's next read
//   mem_read           out  memory read strobe
//   mem_write          out  memory write strobe
//   mem_addr           out  memory address
//   mem_wdata          out  memory write data
//   mem_rdata          in   memory read data (combinational read)
// ----------------------------------------------------------------------------
module data_memory_arbiter
    import data_memory_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              clear_n,
    input  logic              req_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic              req_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              gnt_a,
    output logic              gnt_b,
    output logic              rvalid_a,
    output logic              rvalid_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t            state, state_d;
    req_id_t           last, last_d;
    req_id_t           owner, owner_d;   // requester served by the current access
    logic [1:0]        win;

    logic              gnt_a_d, gnt_b_d;
    logic              rvalid_a_d, rvalid_b_d;
    logic [DATA_W-1:0] rdata_a_d, rdata_b_d;
    logic              mem_read_d, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_d;

    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    rr_arbiter_2 u_pick (
        .req  ({req_b, req_a}),
        .last (last),
        .win  (win)
    );

    // Fields of the winning requester (win is one-hot when non-zero).
    always_comb begin
        sel_we    = win[1] ? we_b    : we_a;
        sel_addr  = win[1] ? addr_b  : addr_a;
        sel_wdata = win[1] ? wdata_b : wdata_a;
    end

    // Next-state and next-output logic. Strobes and pulses default low so
    // they last exactly one cycle; address/data/read results hold.
    always_comb begin
        state_d     = state;
        last_d      = last;
        owner_d     = owner;
        gnt_a_d     = 1'b0;
        gnt_b_d     = 1'b0;
        rvalid_a_d  = 1'b0;
        rvalid_b_d  = 1'b0;
        rdata_a_d   = rdata_a;
        rdata_b_d   = rdata_b;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;

        case (state)
            ST_IDLE: begin
                if (win != 2'b00) begin
                    owner_d     = win[1] ? REQ_B : REQ_A;
                    last_d      = win[1] ? REQ_B : REQ_A;
                    gnt_a_d     = win[0];
                    gnt_b_d     = win[1];
                    mem_write_d = sel_we;
                    mem_read_d  = ~sel_we;
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = sel_wdata;
                    state_d     = ST_ACCESS;
                end
            end

            ST_ACCESS: begin
                // Requests are ignored here; the memory commits a write on the
                // closing edge, a read is captured on the same edge.
                if (mem_read) begin
                    if (owner == REQ_B) begin
                        rdata_b_d  = mem_rdata;
                        rvalid_b_d = 1'b1;
                    end else begin
                        rdata_a_d  = mem_rdata;
                        rvalid_a_d = 1'b1;
                    end
                end
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // Register stage. An asynchronous reset in ACCESS drops mem_write at
    // once, so the memory never commits an aborted write.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state     <= ST_IDLE;
            last      <= REQ_B;
            owner     <= REQ_A;
            gnt_a     <= 1'b0;
            gnt_b     <= 1'b0;
            rvalid_a  <= 1'b0;
            rvalid_b  <= 1'b0;
            rdata_a   <= '0;
            rdata_b   <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state     <= state_d;
            last      <= last_d;
            owner     <= owner_d;
            gnt_a     <= gnt_a_d;
            gnt_b     <= gnt_b_d;
            rvalid_a  <= rvalid_a_d;
            rvalid_b  <= rvalid_b_d;
            rdata_a   <= rdata_a_d;
            rdata_b   <= rdata_b_d;
            mem_read  <= mem_read_d;
            mem_write <= mem_write_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
        end
    end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// ----------------------------------------------------------------------------
// tb_data_memory_arbiter
// Scoreboard bench: a transaction-level model predicts grants and read
// results from the request inputs; a monitor pops and compares whenever the
// DUT pulses gnt or rvalid. Also contains the 32 x 8 data memory.
// ----------------------------------------------------------------------------
module tb_data_memory_arbiter;

    logic       clock;
    logic       clear_n;
    logic       req [2];
    logic       we [2];
    logic [7:0] addr [2];
    logic [7:0] wdata [2];
    logic [1:0] gnt;
    logic [1:0] rvalid;
    logic [7:0] rdata_a, rdata_b;
    logic       mem_read, mem_write;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;

    logic [7:0] mem [32];      // memory attached to the DUT
    logic [7:0] ref_mem [32];  // model's view of memory contents

    int checks = 0;
    int failures = 0;
    int edge_n = 0;
    int gcnt [2];

    typedef struct {
        int         e;
        int         port;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
    } gnt_t;

    typedef struct {
        int         e;
        int         port;
        logic [7:0] data;
    } rv_t;

    gnt_t gq [$];
    rv_t  rq [$];

    data_memory_arbiter dut (
        .clock     (clock),
        .clear_n   (clear_n),
        .req_a     (req[0]),
        .we_a      (we[0]),
        .addr_a    (addr[0]),
        .wdata_a   (wdata[0]),
        .req_b     (req[1]),
        .we_b      (we[1]),
        .addr_b    (addr[1]),
        .wdata_b   (wdata[1]),
        .gnt_a     (gnt[0]),
        .gnt_b     (gnt[1]),
        .rvalid_a  (rvalid[0]),
        .rvalid_b  (rvalid[1]),
        .rdata_a   (rdata_a),
        .rdata_b   (rdata_b),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory: combinational read, write on the rising edge when mem_write.
    assign mem_rdata = mem[mem_addr[4:0]];
    initial begin
        for (int i = 0; i < 32; i++) begin
            mem[i]     = (i == 17) ? 8'hFF : 8'(i);
            ref_mem[i] = (i == 17) ? 8'hFF : 8'(i);
        end
        forever begin
            @(posedge clock);
            if (mem_write) mem[mem_addr[4:0]] = mem_wdata;
        end
    end

    // Reference model: one access every two edges, winner chosen by the
    // arbitration rule, write committed and read answered one edge later.
    bit         m_busy = 0;
    int         m_port = 0;
    int         m_last = 1;
    logic       m_we = 1'b0;
    logic [7:0] m_addr = 8'h00;
    logic [7:0] m_wdata = 8'h00;
    gnt_t       m_g;
    rv_t        m_r;
    initial forever begin
        @(posedge clock);
        edge_n++;
        if (!clear_n) begin
            m_busy = 0;
            m_last = 1;
            m_addr = 8'h00;
            gq.delete();
            rq.delete();
        end else if (m_busy) begin
            m_busy = 0;
            if (m_we) ref_mem[m_addr[4:0]] = m_wdata;
            else begin
                m_r.e    = edge_n;
                m_r.port = m_port;
                m_r.data = ref_mem[m_addr[4:0]];
                rq.push_back(m_r);
            end
        end else if (req[0] || req[1]) begin
            if (req[0] && req[1]) begin
`ifdef ARB_FIXED_PRIORITY_EN
                m_port = 0;
`else
                m_port = (m_last == 0) ? 1 : 0;
`endif
            end else begin
                m_port = req[0] ? 0 : 1;
            end
            m_last    = m_port;
            m_we      = we[m_port];
            m_addr    = addr[m_port];
            m_wdata   = wdata[m_port];
            m_busy    = 1;
            m_g.e     = edge_n;
            m_g.port  = m_port;
            m_g.we    = m_we;
            m_g.addr  = m_addr;
            m_g.wdata = m_wdata;
            gq.push_back(m_g);
        end
    end

    // Monitor: compare DUT events against the model's queues.
    gnt_t o_g;
    rv_t  o_r;
    initial forever begin
        @(negedge clock);
        if (clear_n) begin
            if (gnt != 2'b00) begin
                if (gnt[0]) gcnt[0]++;
                if (gnt[1]) gcnt[1]++;
                chk("gnt_both", int'(gnt == 2'b11), 0);
                if (gq.size() == 0) chk("gnt_unexpected", 1, 0);
                else begin
                    o_g = gq.pop_front();
                    chk("gnt_edge", edge_n, o_g.e);
                    chk("gnt_port", int'(gnt), (o_g.port == 1) ? 2 : 1);
                    chk("mem_write", int'(mem_write), int'(o_g.we));
                    chk("mem_read", int'(mem_read), int'(!o_g.we));
                    chk("mem_addr", int'(mem_addr), int'(o_g.addr));
                    if (o_g.we) chk("mem_wdata", int'(mem_wdata), int'(o_g.wdata));
                end
            end else begin
                chk("idle_strobes", int'({mem_read, mem_write}), 0);
            end
            if (gq.size() != 0 && gq[0].e < edge_n) begin
                chk("gnt_missing", 0, 1);
                void'(gq.pop_front());
            end
            if (rvalid != 2'b00) begin
                if (rq.size() == 0) chk("rvalid_unexpected", int'(rvalid), 0);
                else begin
                    o_r = rq.pop_front();
                    chk("rvalid_edge", edge_n, o_r.e);
                    chk("rvalid_port", int'(rvalid), (o_r.port == 1) ? 2 : 1);
                    chk("rdata", int'((o_r.port == 1) ? rdata_b : rdata_a), int'(o_r.data));
                end
            end
            if (rq.size() != 0 && rq[0].e < edge_n) begin
                chk("rvalid_missing", 0, 1);
                void'(rq.pop_front());
            end
        end
    end

    task automatic settle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        clear_n = 1'b0;
        req[0] = 1'b0;
        req[1] = 1'b0;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        #2 clear_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, int'(gnt), 0);
        chk({tag, "_rvalid"}, int'(rvalid), 0);
        chk({tag, "_strobes"}, int'({mem_read, mem_write}), 0);
        chk({tag, "_mem_addr"}, int'(mem_addr), 0);
        chk({tag, "_mem_wdata"}, int'(mem_wdata), 0);
        chk({tag, "_rdata_a"}, int'(rdata_a), 0);
        chk({tag, "_rdata_b"}, int'(rdata_b), 0);
    endtask

    task automatic wait_gnt(input int p);
        int k = 0;
        do begin
            @(posedge clock);
            #1;
            k++;
        end while (!gnt[p] && k < 60);
        if (!gnt[p]) chk("gnt_timeout", 0, 1);
    endtask

    task automatic access(input int p, input logic w, input logic [7:0] a, input logic [7:0] d);
        we[p]    = w;
        addr[p]  = a;
        wdata[p] = d;
        req[p]   = 1'b1;
        wait_gnt(p);
        req[p]   = 1'b0;
    endtask

    task automatic agent(input int p, input int n);
        for (int i = 0; i < n; i++) begin
            settle($urandom_range(0, 3));
            access(p, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 31)), 8'($urandom));
        end
    endtask

    int ga0, gb0;
    initial begin
        clear_n = 1'b0;
        for (int p = 0; p < 2; p++) begin
            req[p] = 1'b0; we[p] = 1'b0; addr[p] = 8'h00; wdata[p] = 8'h00;
        end
        gcnt[0] = 0;
        gcnt[1] = 0;
        do_reset();
        chk_all_zero("reset");

        // Write then read back through port A.
        access(0, 1'b1, 8'd5, 8'hAA);
        access(0, 1'b0, 8'd5, 8'h00);
        settle(2);
        chk("t1_rdata_a", int'(rdata_a), 8'hAA);

        // Simultaneous reads right after reset: A wins first.
        do_reset();
        we[0] = 1'b0; addr[0] = 8'd1;
        we[1] = 1'b0; addr[1] = 8'd17;
        req[0] = 1'b1; req[1] = 1'b1;
        for (int k = 0; k < 12 && (req[0] || req[1]); k++) begin
            settle(1);
            if (gnt[0]) req[0] = 1'b0;
            if (gnt[1]) req[1] = 1'b0;
        end
        chk("t2_drained", int'(req[0] || req[1]), 0);
        settle(2);
        chk("t2_rdata_a", int'(rdata_a), 8'h01);
        chk("t2_rdata_b", int'(rdata_b), 8'hFF);

`ifdef ARB_FIXED_PRIORITY_EN
        // Continuous tie: only A served until it drops.
        ga0 = gcnt[0]; gb0 = gcnt[1];
        addr[0] = 8'd2; addr[1] = 8'd4;
        req[0] = 1'b1; req[1] = 1'b1;
        settle(10);
        req[0] = 1'b0;
        chk("t5_gnt_a_count", gcnt[0] - ga0, 5);
        chk("t5_gnt_b_count", gcnt[1] - gb0, 0);
        settle(1);
        chk("t5_gnt_b_after_drop", int'(gnt[1]), 1);
        req[1] = 1'b0;
        settle(2);
`else
        // Continuous tie: strict alternation.
        ga0 = gcnt[0]; gb0 = gcnt[1];
        addr[0] = 8'd2; addr[1] = 8'd4;
        req[0] = 1'b1; req[1] = 1'b1;
        settle(8);
        req[0] = 1'b0; req[1] = 1'b0;
        chk("t3_gnt_a_count", gcnt[0] - ga0, 2);
        chk("t3_gnt_b_count", gcnt[1] - gb0, 2);
        settle(2);
`endif

        // Reset during a write access aborts it.
        access(1, 1'b1, 8'd3, 8'h5C);
        @(negedge clock);
        #1 clear_n = 1'b0;
        #1 chk_all_zero("abort");
        @(posedge clock);
        @(negedge clock);
        #2 clear_n = 1'b1;
        settle(1);
        access(0, 1'b0, 8'd3, 8'h00);
        settle(2);
        chk("t4_rdata_a", int'(rdata_a), 8'h03);

        // Idle period: no strobes, address held.
        for (int k = 0; k < 5; k++) begin
            settle(1);
            chk("t6_gnt", int'(gnt), 0);
            chk("t6_rvalid", int'(rvalid), 0);
            chk("t6_strobes", int'({mem_read, mem_write}), 0);
            chk("t6_mem_addr", int'(mem_addr), int'(m_addr));
        end

        // Random concurrent traffic from both ports.
        fork
            agent(0, 40);
            agent(1, 40);
        join
        settle(6);
        chk("drain_gnt_queue", gq.size(), 0);
        chk("drain_rvalid_queue", rq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
